// File: rtl/snoop_bus_master.sv
// snoop_bus_master
// Bus-side master stage used by the L2 controller to put one operation on the
// shared snoop bus. It drives the operation for one cycle, waits snoopDelay
// cycles, samples the snoop result and then either retries after a HITM
// back-off or returns the outcome with a MESI fill-state hint.
//
// Ports:
//   clk                    single clock, all state changes on the rising edge
//   rst_n                  synchronous active-low reset
//   reqValid / reqReady    request handshake (reqReady high only in IDLE)
//   reqOp                  8'h01 READ, 8'h02 WRITE, 8'h03 INVALIDATE, 8'h04 RWIM
//   reqAddr                line address
//   sharedBusOut           address driven to the bus
//   sharedOperationBusOut  operation driven to the bus, 8'h00 = idle
//   snoopBusIn             00 NOHIT, 01 HIT, 10 HITM, 11 reserved
//   respValid              one-cycle completion pulse
//   respSnoop              final sampled snoop result
//   respState              MESI fill state: I = 00, S = 01, E = 10, M = 11
//   respError              error flag, valid with respValid
//
// Optional feature macro: SNOOP_BUS_STATS_EN adds saturating 16-bit counters
// statHit, statHitm, statNohit and statRetry.

module snoop_bus_master #(
  parameter int lineSize      = 512,
  parameter int snoopDelay    = 2,
  parameter int backoffCycles = 4,
  parameter int maxRetries    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic [7:0]          reqOp,
  input  logic [lineSize-1:0] reqAddr,
  output logic [lineSize-1:0] sharedBusOut,
  output logic [7:0]          sharedOperationBusOut,
  input  logic [1:0]          snoopBusIn,
  output logic                respValid,
  output logic [1:0]          respSnoop,
  output logic [1:0]          respState,
`ifdef SNOOP_BUS_STATS_EN
  output logic [15:0]         statHit,
  output logic [15:0]         statHitm,
  output logic [15:0]         statNohit,
  output logic [15:0]         statRetry,
`endif
  output logic                respError
);

  localparam logic [7:0] op_read   = 8'h01;
  localparam logic [7:0] op_write  = 8'h02;
  localparam logic [7:0] op_inval  = 8'h03;
  localparam logic [7:0] op_rwim   = 8'h04;
  localparam logic [7:0] snoop_dly = 8'(snoopDelay);
  localparam logic [7:0] back_dly  = 8'(backoffCycles);
  localparam logic [2:0] max_retry = 3'(maxRetries);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DECIDE, BACKOFF, RESP} state_t;

  state_t              state, next_state;
  logic [7:0]          op_q;
  logic [lineSize-1:0] addr_q;
  logic [7:0]          cnt;
  logic [2:0]          retries;
  logic [1:0]          snoop_q;

  logic                legal_op, read_like, snoop_hitm, can_retry;
  logic                decide_error;
  logic [1:0]          decide_state;
  logic [7:0]          op_next;
  logic [lineSize-1:0] addr_next;

  logic                ready_d, valid_d, error_d;
  logic [7:0]          bus_op_d;
  logic [lineSize-1:0] bus_addr_d;
  logic [1:0]          snoop_d, state_d;

  // Outcome of the DECIDE step, derived from the latched op and last sample.
  // An illegal op reaches DECIDE with snoop_q cleared, so it only errors.
  always_comb begin
    legal_op     = (op_q == op_read) || (op_q == op_write) ||
                   (op_q == op_inval) || (op_q == op_rwim);
    read_like    = (op_q == op_read) || (op_q == op_rwim);
    snoop_hitm   = (snoop_q == 2'b10);
    can_retry    = read_like && snoop_hitm && (retries < max_retry);
    decide_error = !legal_op || (snoop_q == 2'b11) ||
                   (snoop_hitm && (op_q == op_inval)) ||
                   (snoop_hitm && read_like && !can_retry);
    decide_state = 2'b00;
    if (!decide_error) begin
      case (op_q)
        op_read:  decide_state = (snoop_q == 2'b01) ? 2'b01 : 2'b10;
        op_rwim:  decide_state = 2'b11;
        op_inval: decide_state = 2'b11;
        default:  decide_state = 2'b00;
      endcase
    end
  end

  // State register plus latched request, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= IDLE;
      op_q                  <= 8'h00;
      addr_q                <= '0;
      cnt                   <= 8'd0;
      retries               <= 3'd0;
      snoop_q               <= 2'b00;
      reqReady              <= 1'b1;
      sharedOperationBusOut <= 8'h00;
      sharedBusOut          <= '0;
      respValid             <= 1'b0;
      respSnoop             <= 2'b00;
      respState             <= 2'b00;
      respError             <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (reqValid) begin
            op_q    <= reqOp;
            addr_q  <= reqAddr;
            snoop_q <= 2'b00;
            retries <= 3'd0;
          end
        end
        ISSUE:   cnt <= 8'd1;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == snoop_dly) snoop_q <= snoopBusIn;
        end
        DECIDE: begin
          if (can_retry) begin
            retries <= retries + 3'd1;
            cnt     <= 8'd1;
          end
        end
        BACKOFF: cnt <= cnt + 8'd1;
        RESP:    retries <= 3'd0;
        default: ;
      endcase
      reqReady              <= ready_d;
      sharedOperationBusOut <= bus_op_d;
      sharedBusOut          <= bus_addr_d;
      respValid             <= valid_d;
      respSnoop             <= snoop_d;
      respState             <= state_d;
      respError             <= error_d;
    end
  end

  // Next-state logic. Illegal ops skip the bus entirely and go straight to
  // DECIDE so they respond on the following cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (reqValid) begin
          if ((reqOp >= op_read) && (reqOp <= op_rwim)) next_state = ISSUE;
          else                                           next_state = DECIDE;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (cnt == snoop_dly) next_state = DECIDE;
      DECIDE:  next_state = can_retry ? BACKOFF : RESP;
      BACKOFF: if (cnt == back_dly) next_state = ISSUE;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output values are computed from the next state so the registered outputs
  // line up with the state they describe. On acceptance the op and address
  // are not latched yet, so they are taken straight from the request.
  always_comb begin
    op_next    = (state == IDLE) ? reqOp : op_q;
    addr_next  = (state == IDLE) ? reqAddr : addr_q;
    ready_d    = (next_state == IDLE);
    bus_op_d   = (next_state == ISSUE) ? op_next : 8'h00;
    bus_addr_d = ((next_state == ISSUE) || (next_state == WAIT)) ? addr_next : '0;
    valid_d    = (next_state == RESP);
    snoop_d    = respSnoop;
    state_d    = respState;
    error_d    = respError;
    if (next_state == RESP) begin
      snoop_d = snoop_q;
      state_d = decide_state;
      error_d = decide_error;
    end
  end

`ifdef SNOOP_BUS_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics only count real bus samples, never the illegal-op shortcut.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      statHit   <= 16'd0;
      statHitm  <= 16'd0;
      statNohit <= 16'd0;
      statRetry <= 16'd0;
    end else if ((state == DECIDE) && legal_op) begin
      if (snoop_q == 2'b01) statHit   <= sat_inc(statHit);
      if (snoop_q == 2'b10) statHitm  <= sat_inc(statHitm);
      if (snoop_q == 2'b00) statNohit <= sat_inc(statNohit);
      if (can_retry)        statRetry <= sat_inc(statRetry);
    end
  end
`endif

endmodule

// File: tb/tb_snoop_bus_master.sv
// tb_snoop_bus_master
// Directed, table-driven bench for snoop_bus_master with default parameters.
// Each table row is one transaction with hand-computed bus issue count,
// response cycle (cycle 1 is the cycle right after the accepting edge) and
// response fields. Extra hand sequences cover reset mid-operation.

module tb_snoop_bus_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         reqValid;
  logic         reqReady;
  logic [7:0]   reqOp;
  logic [511:0] reqAddr;
  logic [511:0] sharedBusOut;
  logic [7:0]   sharedOperationBusOut;
  logic [1:0]   snoopBusIn;
  logic         respValid;
  logic [1:0]   respSnoop;
  logic [1:0]   respState;
  logic         respError;
`ifdef SNOOP_BUS_STATS_EN
  logic [15:0]  statHit, statHitm, statNohit, statRetry;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snoop_bus_master dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .reqValid              (reqValid),
    .reqReady              (reqReady),
    .reqOp                 (reqOp),
    .reqAddr               (reqAddr),
    .sharedBusOut          (sharedBusOut),
    .sharedOperationBusOut (sharedOperationBusOut),
    .snoopBusIn            (snoopBusIn),
    .respValid             (respValid),
    .respSnoop             (respSnoop),
    .respState             (respState),
`ifdef SNOOP_BUS_STATS_EN
    .statHit               (statHit),
    .statHitm              (statHitm),
    .statNohit             (statNohit),
    .statRetry             (statRetry),
`endif
    .respError             (respError)
  );

  typedef struct {
    string      name;
    logic [7:0] op;
    logic [31:0] addr;
    logic [1:0] snoop;
    int         hitmIssues;
    bit         poke;
    int         expIssues;
    int         expCycle;
    bit         chkSnoop;
    logic [1:0] expSnoop;
    logic [1:0] expState;
    logic       expError;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Runs one transaction from the table, starting #1 after a rising edge.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    int issues;
    int badBus;
    int firstIssue;
    int secondIssue;
    bit gotResp;
    int waitCyc;
    waitCyc = 0;
    while (!reqReady && waitCyc < 20) begin
      @(posedge clk); #1; waitCyc++;
    end
    checkOutput({v.name, "_ready"}, 32'(reqReady), 32'd1);
    reqValid   = 1'b1;
    reqOp      = v.op;
    reqAddr    = '0;
    reqAddr[31:0] = v.addr;
    snoopBusIn = (v.hitmIssues > 0) ? 2'b10 : v.snoop;
    @(posedge clk); #1;
    reqValid = 1'b0;
    cyc = 1; issues = 0; badBus = 0; firstIssue = 0; secondIssue = 0;
    gotResp = 1'b0;
    while (cyc <= 60) begin
      if (sharedOperationBusOut != 8'h00) begin
        issues++;
        if (issues == 1) firstIssue = cyc;
        if (issues == 2) secondIssue = cyc;
        if (sharedOperationBusOut != v.op || sharedBusOut[31:0] != v.addr ||
            sharedBusOut[511:32] != '0) badBus++;
      end
      snoopBusIn = (issues <= v.hitmIssues) ? 2'b10 : v.snoop;
      if (v.poke) begin
        if (cyc == 2) checkOutput({v.name, "_busy_ready"}, 32'(reqReady), 32'd0);
        reqValid = (cyc == 2 || cyc == 3);
        reqOp    = 8'h02;
        reqAddr  = 512'h99;
      end
      if (respValid) begin
        gotResp = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    reqValid = 1'b0;
    checkOutput({v.name, "_got_resp"}, 32'(gotResp), 32'd1);
    checkOutput({v.name, "_resp_cycle"}, 32'(cyc), 32'(v.expCycle));
    checkOutput({v.name, "_issues"}, 32'(issues), 32'(v.expIssues));
    checkOutput({v.name, "_bus_content_bad"}, 32'(badBus), 32'd0);
    if (v.expIssues > 1)
      checkOutput({v.name, "_reissue_gap"}, 32'(secondIssue - firstIssue), 32'd8);
    if (v.chkSnoop) checkOutput({v.name, "_respSnoop"}, 32'(respSnoop), 32'(v.expSnoop));
    checkOutput({v.name, "_respState"}, 32'(respState), 32'(v.expState));
    checkOutput({v.name, "_respError"}, 32'(respError), 32'(v.expError));
    @(posedge clk); #1;
    checkOutput({v.name, "_pulse_one_cycle"}, 32'(respValid), 32'd0);
    checkOutput({v.name, "_ready_after"}, 32'(reqReady), 32'd1);
  endtask

  initial begin
    int quiet;
`ifdef SNOOP_BUS_STATS_EN
    logic [63:0] statsBefore;
`endif
    //          name          op     addr   snp  hI poke iss cyc chk expS  expSt expE
    vecs[0]  = '{"read_nohit",  8'h01, 32'h40, 2'b00, 0, 0, 1, 5,  1, 2'b00, 2'b10, 1'b0};
    vecs[1]  = '{"read_hit",    8'h01, 32'h44, 2'b01, 0, 0, 1, 5,  1, 2'b01, 2'b01, 1'b0};
    vecs[2]  = '{"write_nohit", 8'h02, 32'h48, 2'b00, 0, 0, 1, 5,  1, 2'b00, 2'b00, 1'b0};
    vecs[3]  = '{"write_hitm",  8'h02, 32'h4C, 2'b10, 0, 0, 1, 5,  1, 2'b10, 2'b00, 1'b0};
    vecs[4]  = '{"inval_hitm",  8'h03, 32'h50, 2'b10, 0, 0, 1, 5,  1, 2'b10, 2'b00, 1'b1};
    vecs[5]  = '{"inval_nohit", 8'h03, 32'h54, 2'b00, 0, 0, 1, 5,  1, 2'b00, 2'b11, 1'b0};
    vecs[6]  = '{"rwim_hit",    8'h04, 32'h58, 2'b01, 0, 0, 1, 5,  1, 2'b01, 2'b11, 1'b0};
    vecs[7]  = '{"read_rsvd",   8'h01, 32'h5C, 2'b11, 0, 0, 1, 5,  1, 2'b11, 2'b00, 1'b1};
    vecs[8]  = '{"rwim_2hitm",  8'h04, 32'h60, 2'b00, 2, 0, 3, 21, 1, 2'b00, 2'b11, 1'b0};
    vecs[9]  = '{"read_1hitm",  8'h01, 32'h64, 2'b01, 1, 0, 2, 13, 1, 2'b01, 2'b01, 1'b0};
    vecs[10] = '{"read_hitm",   8'h01, 32'h68, 2'b10, 0, 0, 4, 29, 1, 2'b10, 2'b00, 1'b1};
    vecs[11] = '{"rwim_hitm",   8'h04, 32'h6C, 2'b10, 0, 0, 4, 29, 1, 2'b10, 2'b00, 1'b1};
    vecs[12] = '{"busy_poke",   8'h01, 32'h70, 2'b00, 0, 1, 1, 5,  1, 2'b00, 2'b10, 1'b0};
    vecs[13] = '{"illegal_op",  8'h07, 32'h74, 2'b00, 0, 0, 0, 2,  0, 2'b00, 2'b00, 1'b1};

    rst_n = 1'b0; reqValid = 1'b0; reqOp = 8'h00; reqAddr = '0; snoopBusIn = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("reset_ready", 32'(reqReady), 32'd1);
    checkOutput("reset_busop", 32'(sharedOperationBusOut), 32'd0);
    checkOutput("reset_bus_zero", 32'(sharedBusOut != '0), 32'd0);
    checkOutput("reset_respValid", 32'(respValid), 32'd0);

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

`ifdef SNOOP_BUS_STATS_EN
    statsBefore = {statHit, statHitm, statNohit, statRetry};
`endif
    applyStimulus(vecs[13]);
`ifdef SNOOP_BUS_STATS_EN
    checkOutput("illegal_stats_hit", 32'(statHit), 32'(statsBefore[63:48]));
    checkOutput("illegal_stats_nohit", 32'(statNohit), 32'(statsBefore[31:16]));
`endif

    // Reset in the middle of the snoop window must abort with no pulse.
    reqValid = 1'b1; reqOp = 8'h01; reqAddr = 512'h80; snoopBusIn = 2'b00;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midwait_ready", 32'(reqReady), 32'd1);
    checkOutput("midwait_busop", 32'(sharedOperationBusOut), 32'd0);
    checkOutput("midwait_respValid", 32'(respValid), 32'd0);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (respValid) quiet++;
    end
    checkOutput("midwait_no_pulse", 32'(quiet), 32'd0);

    applyStimulus(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
